// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DW_DEF = 16;
    localparam int VW_DEF = 8;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/rca_adder.sv
// Parameterized ripple-carry adder; used as the divider's trial subtractor.
module rca_adder #(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W:0] carry_s;

    assign carry_s[0] = cin_i;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum_o[i]       = a_i[i] ^ b_i[i] ^ carry_s[i];
        assign carry_s[i + 1] = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry_s[W];

endmodule

// File: rtl/seq_divider_rca.sv
// Sequential restoring divider: one quotient bit per clock, MSB first,
// with the trial subtraction done by a ripple-carry adder.
module seq_divider_rca
    import div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DW - 1);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Upper VW bits: running remainder; lower DW bits: dividend shifting out, quotient shifting in.
    logic [VW+DW-1:0]   sr_q, sr_d;
    logic [VW-1:0]      div_q, div_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [DW-1:0]      quot_q, quot_d;
    logic [VW-1:0]      rem_q, rem_d;

    logic [VW:0]        partial_s;
    logic [VW:0]        trial_s;
    logic               no_borrow_s;
    logic [VW-1:0]      r_next_s;
    logic               unused_s;

    assign partial_s = {sr_q[VW+DW-1:DW], sr_q[DW-1]};

    rca_adder #(
        .W (VW + 1)
    ) u_sub (
        .a_i    (partial_s),
        .b_i    (~{1'b0, div_q}),
        .cin_i  (1'b1),
        .sum_o  (trial_s),
        .cout_o (no_borrow_s)
    );

    // Both candidates are below the divisor, so the top bit is always zero.
    assign r_next_s = no_borrow_s ? trial_s[VW-1:0] : partial_s[VW-1:0];
    assign unused_s = trial_s[VW];

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        div_d   = div_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = {CNT_W{1'b0}};
                    sr_d    = {{VW{1'b0}}, dividend};
                    div_d   = divisor;
                    dbz_d   = 1'b0;
                    busy_d  = (divisor != {VW{1'b0}});
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // A zero divisor spends its single RUN cycle with busy low, then reports.
                if (div_q == {VW{1'b0}}) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    dbz_d   = 1'b1;
                    quot_d  = {DW{1'b1}};
                    rem_d   = sr_q[VW-1:0];
                end else begin
                    sr_d  = {r_next_s, sr_q[DW-2:0], no_borrow_s};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        quot_d  = {sr_q[DW-2:0], no_borrow_s};
                        rem_d   = r_next_s;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            sr_q    <= {(VW+DW){1'b0}};
            div_q   <= {VW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= {DW{1'b0}};
            rem_q   <= {VW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            div_q   <= div_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign dbz       = dbz_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_seq_divider_rca.sv
// Self-checking bench for seq_divider_rca: directed cases plus random operands
// checked against plain integer division.
module tb_seq_divider_rca;

    localparam int DW = 16;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dbz;

    int errors = 0;
    int checks = 0;

    seq_divider_rca #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge, then scramble the inputs.
    task automatic do_accept(input logic [DW-1:0] a, input logic [VW-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        start    = 1'b0;
        dividend = 16'($urandom());
        divisor  = 8'($urandom());
    endtask

    // Wait for done and compare against the arithmetic reference; optionally
    // pulse a competing start at cycle 'poke' after the accept.
    task automatic wait_result(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                               input int poke);
        int n      = 1;
        int busy_n = 0;
        int ai     = int'(a);
        int bi     = int'(b);
        int exp_q;
        int exp_r;
        bit dz     = (bi == 0);
        exp_q = dz ? 32'h0000_FFFF : ai / bi;
        exp_r = dz ? (ai % 256) : ai % bi;
        while (!done && n < 40) begin
            if (busy) busy_n++;
            if (n == poke) begin
                start    = 1'b1;
                dividend = 16'd12000;
                divisor  = 8'd100;
            end
            step();
            start = 1'b0;
            n++;
        end
        check_val({tag, " latency"}, 32'(n), dz ? 32'd2 : 32'd17);
        check_val({tag, " busy_cycles"}, 32'(busy_n), dz ? 32'd0 : 32'd16);
        check_val({tag, " done"}, 32'(done), 32'd1);
        check_val({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check_val({tag, " quotient"}, 32'(quotient), 32'(exp_q));
        check_val({tag, " remainder"}, 32'(remainder), 32'(exp_r));
        check_val({tag, " dbz"}, 32'(dbz), 32'(dz));
    endtask

    // One cycle after done: pulse must be gone and the result held.
    task automatic finish_pulse(input string tag, input logic [DW-1:0] q, input logic [VW-1:0] r);
        step();
        check_val({tag, " done_width"}, 32'(done), 32'd0);
        check_val({tag, " hold_q"}, 32'(quotient), 32'(q));
        check_val({tag, " hold_r"}, 32'(remainder), 32'(r));
    endtask

    initial begin
        int done_seen;
        logic [DW-1:0] a;
        logic [VW-1:0] b;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        step();
        step();
        check_val("reset busy", 32'(busy), 32'd0);
        check_val("reset done", 32'(done), 32'd0);
        check_val("reset dbz", 32'(dbz), 32'd0);
        check_val("reset quotient", 32'(quotient), 32'd0);
        check_val("reset remainder", 32'(remainder), 32'd0);

        // First accept on the very first edge with rst low.
        rst = 1'b0;
        do_accept(16'd20000, 8'd200);
        wait_result("20000/200", 16'd20000, 8'd200, 0);
        finish_pulse("20000/200", 16'd100, 8'd0);

        do_accept(16'd1000, 8'd7);
        wait_result("1000/7", 16'd1000, 8'd7, 0);
        finish_pulse("1000/7", 16'd142, 8'd6);

        do_accept(16'd65535, 8'd1);
        wait_result("65535/1", 16'd65535, 8'd1, 0);
        finish_pulse("65535/1", 16'd65535, 8'd0);

        do_accept(16'd5, 8'd9);
        wait_result("5/9", 16'd5, 8'd9, 0);
        finish_pulse("5/9", 16'd0, 8'd5);

        do_accept(16'd100, 8'd0);
        check_val("dbz no_busy", 32'(busy), 32'd0);
        wait_result("100/0", 16'd100, 8'd0, 0);
        finish_pulse("100/0", 16'hFFFF, 8'd100);

        // Start mid-run is ignored, start in the DONE cycle is accepted.
        do_accept(16'd20000, 8'd200);
        wait_result("ignore_mid", 16'd20000, 8'd200, 6);
        do_accept(16'd12000, 8'd100);
        check_val("b2b done_cleared", 32'(done), 32'd0);
        check_val("b2b busy", 32'(busy), 32'd1);
        wait_result("b2b 12000/100", 16'd12000, 8'd100, 0);
        finish_pulse("b2b 12000/100", 16'd120, 8'd0);

        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; dividend = 16'd777; divisor = 8'd3;
        step();
        rst = 1'b0; start = 1'b0;
        check_val("rst_over_start busy", 32'(busy), 32'd0);
        step();
        check_val("rst_over_start busy2", 32'(busy), 32'd0);

        // Reset mid-run aborts with no done pulse.
        do_accept(16'd30000, 8'd3);
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("abort busy", 32'(busy), 32'd0);
        check_val("abort done", 32'(done), 32'd0);
        check_val("abort quotient", 32'(quotient), 32'd0);
        check_val("abort remainder", 32'(remainder), 32'd0);
        check_val("abort dbz", 32'(dbz), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) done_seen++;
            step();
        end
        check_val("abort no_done", 32'(done_seen), 32'd0);
        do_accept(16'd10000, 8'd50);
        wait_result("10000/50", 16'd10000, 8'd50, 0);
        finish_pulse("10000/50", 16'd200, 8'd0);

        for (int k = 0; k < 1000; k++) begin
            a = 16'($urandom());
            b = 8'($urandom_range(255, 1));
            do_accept(a, b);
            wait_result("rand", a, b, 0);
            finish_pulse("rand", 16'(int'(a) / int'(b)), 8'(int'(a) % int'(b)));
            if ($urandom_range(3, 0) == 0) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
